alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Sequences one ArithmeticUnit operation per request: fetches operand A, then operand B, from the shared 8-bit data bus; drives the ArithmeticUnit for one cycle; captures its result; computes the flags; and drives the result back onto the bus.
- Sits between the CPU control logic (start/done handshake) and the combinational ArithmeticUnit.
- Provides the carry, zero and negative flags the ArithmeticUnit does not generate.

Parameters:
DATA_WIDTH, 8, width of operands, result and bus.
ACK_TIMEOUT, 15, maximum WRITEBACK cycles waiting for busAck before abort; 0 disables the timeout.

Ports:
clock  input  1  system clock, rising edge.
resetN  input  1  reset, asynchronous, active-low.
start  input  1  request; sampled only in IDLE.
opcode  input  3  requested operation, latched with start; 3'b100 ADD, 3'b101 SUB.
busIn  input  DATA_WIDTH  shared bus read data.
busValid  input  1  busIn holds a valid operand this cycle.
busAck  input  1  bus consumer has taken busOut.
busOut  output  DATA_WIDTH  result register, driven toward the bus.
busOutEnable  output  1  tri-state enable for busOut at top level.
aluOpcode  output  3  to ArithmeticUnit opcode.
aluOperandA  output  DATA_WIDTH  to ArithmeticUnit operandA (operand A register).
aluOperandB  output  DATA_WIDTH  to ArithmeticUnit operandB (operand B register).
aluResult  input  DATA_WIDTH  from ArithmeticUnit result.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse on completion, abort or illegal request.
carryFlag  output  1  see flag rules.
zeroFlag  output  1  result == 0.
negativeFlag  output  1  result MSB.
illegalOp  output  1  last request had an unsupported opcode.
timeoutError  output  1  last request aborted in WRITEBACK.

Behaviour:
- Reset (asynchronous, immediate on resetN low):
  - state IDLE.
  - All registers, flags and error bits 0; all outputs 0.
  - busOutEnable drops in the same instant, including mid-operation; no done pulse.
- State IDLE:
  - start=1 with opcode 100/101: latch opcode; clear illegalOp and timeoutError; go to LOAD_A.
  - start=1 with any other opcode: set illegalOp; done=1 the next cycle; remain IDLE; flags and registers unchanged.
  - busValid in the start cycle is ignored.
- State LOAD_A: wait on busValid; on busValid=1, register busIn into operand A; go to LOAD_B.
- State LOAD_B: same as LOAD_A, into operand B; go to EXECUTE.
- State EXECUTE (exactly one cycle):
  - aluOpcode = latched opcode.
  - At the clock edge, capture aluResult into busOut and update all three flags.
  - Go to WRITEBACK.
- State WRITEBACK:
  - busOutEnable=1; busOut stable.
  - On busAck=1: go to IDLE; done=1 the following cycle.
  - Timeout counter starts at 0 on entry and increments each cycle without busAck. If it reaches ACK_TIMEOUT: set timeoutError, go to IDLE, pulse done. Flags and busOut keep their captured values.
- aluOpcode is 3'b000 outside EXECUTE.
- aluOperandA and aluOperandB always reflect the operand registers.
- start while busy is ignored; it is not queued.
- Flag rules:
  - ADD: carry = bit DATA_WIDTH of the (DATA_WIDTH+1)-bit sum A+B.
  - SUB: carry = no-borrow, i.e. 1 when A >= B unsigned.
  - zeroFlag and negativeFlag come from the captured result.
  - The result wraps modulo 2^DATA_WIDTH.
- Minimum latency, with busValid and busAck asserted as early as possible and start in cycle 0:
  - LOAD_A in cycle 1, LOAD_B in cycle 2, EXECUTE in cycle 3, WRITEBACK in cycle 4.
  - done high in cycle 5.
- Every done pulse lasts exactly one cycle. busy is low in the cycle done is high.

Test Plan:
- Reset then idle:
  - Stimulus: hold resetN low for 2 cycles, then release.
  - Required: all outputs 0 and busy=0.
  - Stimulus: assert resetN low during WRITEBACK.
  - Required: busOutEnable drops immediately and the block returns to IDLE.
- ADD with carry:
  - Stimulus: opcode=100, operands A=0xFF, B=0x55, back-to-back busValid, busAck in the first WRITEBACK cycle.
  - Required: busOut=0x54, carry=1, zero=0, negative=0, done in cycle 5.
- SUB with borrow:
  - Stimulus: opcode=101, A=0x00, B=0x55.
  - Required: busOut=0xAB, carry=0, negative=1.
  - Stimulus: A=0x0F, B=0x55.
  - Required: busOut=0xBA, carry=0.
  - Stimulus: A=0xFF, B=0x55.
  - Required: busOut=0xAA, carry=1.
- Stalls and zero flag:
  - Stimulus: ADD A=0x00, B=0x00, busValid delayed 3 cycles per operand, busAck delayed 4 cycles.
  - Required: FSM holds each state, busOut=0x00, zero=1, done exactly once.
  - Stimulus: start pulses while busy.
  - Required: ignored.
- Illegal opcode:
  - Stimulus: opcode=011 in IDLE.
  - Required: illegalOp=1, done pulse next cycle, busy stays 0, previous flags unchanged.
  - Stimulus: next legal start.
  - Required: illegalOp clears.
- Timeout:
  - Stimulus: ADD A=0x0F, B=0x55, busAck never asserted.
  - Required: busOut=0x64; after 15 WRITEBACK cycles timeoutError=1, done pulse, busOutEnable=0, return to IDLE.

Source files
------------

// File: rtl/alu_sequencer.sv
// Operand fetch / execute / writeback sequencer wrapped around a combinational
// ArithmeticUnit, adding carry, zero and negative flags plus an ack timeout.
module alu_sequencer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] busIn,
  input  logic                  busValid,
  input  logic                  busAck,
  output logic [DATA_WIDTH-1:0] busOut,
  output logic                  busOutEnable,
  output logic [2:0]            aluOpcode,
  output logic [DATA_WIDTH-1:0] aluOperandA,
  output logic [DATA_WIDTH-1:0] aluOperandB,
  input  logic [DATA_WIDTH-1:0] aluResult,
  output logic                  busy,
  output logic                  done,
  output logic                  carryFlag,
  output logic                  zeroFlag,
  output logic                  negativeFlag,
  output logic                  illegalOp,
  output logic                  timeoutError
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_A    = 3'd1,
    S_LOAD_B    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b000;

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;
  localparam bit TO_EN = (ACK_TIMEOUT > 0);

  function automatic logic is_legal(input logic [2:0] op);
    case (op)
      OP_ADD:  return 1'b1;
      OP_SUB:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // For SUB the carry is the no-borrow bit, so it is set when A >= B.
  function automatic logic calc_carry(input logic [2:0] op,
                                      input logic [DATA_WIDTH-1:0] a,
                                      input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD:  return sum[DATA_WIDTH];
      OP_SUB:  return (a >= b);
      default: return 1'b0;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [2:0]            opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  carry_q, carry_d;
  logic                  zero_q, zero_d;
  logic                  neg_q, neg_d;
  logic                  illegal_q, illegal_d;
  logic                  timeout_q, timeout_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  oe_q, oe_d;
  logic [2:0]            aluop_q, aluop_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Next-state, datapath capture and registered-output decode.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_legal(opcode)) begin
            opcode_d  = opcode;
            illegal_d = 1'b0;
            timeout_d = 1'b0;
            state_d   = S_LOAD_A;
          end else begin
            illegal_d = 1'b1;
            done_d    = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_A: begin
        if (busValid) begin
          opa_d   = busIn;
          state_d = S_LOAD_B;
        end else begin
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_B: begin
        if (busValid) begin
          opb_d   = busIn;
          state_d = S_EXECUTE;
        end else begin
          state_d = S_LOAD_B;
        end
      end
      S_EXECUTE: begin
        result_d = aluResult;
        carry_d  = calc_carry(opcode_q, opa_q, opb_q);
        zero_d   = (aluResult == '0);
        neg_d    = aluResult[DATA_WIDTH-1];
        cnt_d    = '0;
        state_d  = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        if (busAck) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          // The counter would reach ACK_TIMEOUT on this edge: abort.
          timeout_d = 1'b1;
          done_d    = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    oe_d    = (state_d == S_WRITEBACK);
    aluop_d = (state_d == S_EXECUTE) ? opcode_d : OP_NOP;
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      opcode_q  <= 3'b000;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      oe_q      <= 1'b0;
      aluop_q   <= 3'b000;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      oe_q      <= oe_d;
      aluop_q   <= aluop_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busOut       = result_q;
  assign busOutEnable = oe_q;
  assign aluOpcode    = aluop_q;
  assign aluOperandA  = opa_q;
  assign aluOperandB  = opb_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign carryFlag    = carry_q;
  assign zeroFlag     = zero_q;
  assign negativeFlag = neg_q;
  assign illegalOp    = illegal_q;
  assign timeoutError = timeout_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table-driven operations plus stall,
// illegal-opcode, timeout and mid-writeback reset sequences, with a scoreboard.
module tb_alu_sequencer;

  localparam logic [2:0] ADD = 3'b100;
  localparam logic [2:0] SUB = 3'b101;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       start = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [7:0] busIn = 8'h00;
  logic       busValid = 1'b0;
  logic       busAck = 1'b0;
  logic [7:0] busOut, aluOperandA, aluOperandB, aluResult;
  logic [2:0] aluOpcode;
  logic       busOutEnable, busy, done, carryFlag, zeroFlag, negativeFlag;
  logic       illegalOp, timeoutError;

  alu_sequencer #(.DATA_WIDTH(8), .ACK_TIMEOUT(15)) dut (
    .clock(clock), .resetN(resetN), .start(start), .opcode(opcode),
    .busIn(busIn), .busValid(busValid), .busAck(busAck),
    .busOut(busOut), .busOutEnable(busOutEnable), .aluOpcode(aluOpcode),
    .aluOperandA(aluOperandA), .aluOperandB(aluOperandB), .aluResult(aluResult),
    .busy(busy), .done(done), .carryFlag(carryFlag), .zeroFlag(zeroFlag),
    .negativeFlag(negativeFlag), .illegalOp(illegalOp), .timeoutError(timeoutError)
  );

  always #5 clock = ~clock;

  // Behavioural ArithmeticUnit
  always_comb begin
    case (aluOpcode)
      ADD:     aluResult = aluOperandA + aluOperandB;
      SUB:     aluResult = aluOperandA - aluOperandB;
      default: aluResult = 8'h00;
    endcase
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       c;
    logic       z;
    logic       n;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic       c;
    logic       z;
    logic       n;
    logic       ill;
    logic       to;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  vec_t vecs[7];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  function automatic exp_t mk(input logic [7:0] out, input logic c, input logic z,
                              input logic n, input logic ill, input logic to);
    exp_t e;
    e.out = out; e.c = c; e.z = z; e.n = n; e.ill = ill; e.to = to;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse retires the oldest expected result
  always @(negedge clock) begin
    if (resetN && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_done at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_busOut", busOut, e.out);
        check("sb_carry", carryFlag, e.c);
        check("sb_zero", zeroFlag, e.z);
        check("sb_negative", negativeFlag, e.n);
        check("sb_illegalOp", illegalOp, e.ill);
        check("sb_timeoutError", timeoutError, e.to);
      end
    end
  end

  task automatic finish_done(input int base);
    check("done_pulse", done, 1);
    check("idle_on_done", {busy, busOutEnable}, 2'b00);
    @(posedge clock); #1;
    check("done_one_cycle", done, 0);
    check("done_count", done_cnt - base, 1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int da, input int db, input int dack, input bit no_ack,
                        input exp_t e);
    int cyc;
    int base;
    int wb;
    @(posedge clock); #1;
    start = 1'b1; opcode = op;
    busValid = 1'b1; busIn = 8'hEE;
    sb.push_back(e);
    base = done_cnt;
    @(posedge clock); #1;
    start = 1'b0; busValid = 1'b0;
    cyc = 1;
    check("busy_load_a", busy, 1);
    for (int i = 0; i < da; i++) begin
      start = 1'b1; opcode = 3'b011;
      @(posedge clock); #1;
      start = 1'b0; cyc++;
      check("hold_load_a", {busy, busOutEnable, aluOpcode}, {1'b1, 1'b0, 3'b000});
    end
    busValid = 1'b1; busIn = a;
    @(posedge clock); #1;
    busValid = 1'b0; cyc++;
    check("operand_a", aluOperandA, a);
    for (int i = 0; i < db; i++) begin
      start = 1'b1; opcode = ADD;
      @(posedge clock); #1;
      start = 1'b0; cyc++;
      check("hold_load_b", {busy, busOutEnable, aluOpcode}, {1'b1, 1'b0, 3'b000});
    end
    busValid = 1'b1; busIn = b;
    @(posedge clock); #1;
    busValid = 1'b0; busIn = 8'h00; cyc++;
    check("exec_opcode", aluOpcode, op);
    check("operand_b", aluOperandB, b);
    @(posedge clock); #1;
    cyc++;
    check("wb_enable", busOutEnable, 1);
    check("wb_busOut", busOut, e.out);
    check("wb_aluOpcode", aluOpcode, 0);
    if (!no_ack) begin
      for (int i = 0; i < dack; i++) begin
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; cyc++;
        check("hold_wb", {busy, busOutEnable, busOut}, {1'b1, 1'b1, e.out});
      end
      busAck = 1'b1;
      @(posedge clock); #1;
      busAck = 1'b0; cyc++;
      check("latency", cyc, 5 + da + db + dack);
    end else begin
      wb = 1;
      while (busOutEnable && wb < 40) begin
        @(posedge clock); #1;
        if (busOutEnable) wb++;
      end
      check("timeout_wb_cycles", wb, 15);
    end
    finish_done(base);
    last = e;
  endtask

  task automatic run_illegal(input logic [2:0] op, input exp_t e);
    int base;
    @(posedge clock); #1;
    start = 1'b1; opcode = op;
    sb.push_back(e);
    base = done_cnt;
    @(posedge clock); #1;
    start = 1'b0;
    check("illegal_flag", illegalOp, 1);
    check("illegal_busy", busy, 0);
    finish_done(base);
    check("illegal_stays_idle", busy, 0);
    last = e;
  endtask

  initial begin
    vecs[0] = '{ADD, 8'hFF, 8'h55, 8'h54, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{SUB, 8'h00, 8'h55, 8'hAB, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{SUB, 8'h0F, 8'h55, 8'hBA, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{SUB, 8'hFF, 8'h55, 8'hAA, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{SUB, 8'h55, 8'h55, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};

    resetN = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busOut", busOut, 0);
    check("rst_ctrl", {busOutEnable, busy, done, carryFlag, zeroFlag, negativeFlag,
                       illegalOp, timeoutError}, 8'h00);
    check("rst_alu", {aluOpcode, aluOperandA, aluOperandB}, 19'h0);
    resetN = 1'b1;
    @(posedge clock); #1;
    check("idle_after_rst", {busy, done, busOutEnable}, 3'b000);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, 0, 1'b0,
             mk(vecs[i].out, vecs[i].c, vecs[i].z, vecs[i].n, 1'b0, 1'b0));
    end

    // Stalls everywhere with start pulses while busy
    run_op(ADD, 8'h00, 8'h00, 3, 3, 4, 1'b0, mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    check("busy_start_ignored", illegalOp, 0);

    run_illegal(3'b011, mk(last.out, last.c, last.z, last.n, 1'b1, last.to));
    run_op(SUB, 8'h0F, 8'h55, 0, 0, 0, 1'b0, mk(8'hBA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));

    run_op(ADD, 8'h0F, 8'h55, 0, 0, 0, 1'b1, mk(8'h64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    run_illegal(3'b111, mk(last.out, last.c, last.z, last.n, 1'b1, last.to));
    run_op(ADD, 8'h01, 8'h02, 1, 0, 2, 1'b0, mk(8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Reset asserted mid-WRITEBACK
    @(posedge clock); #1;
    start = 1'b1; opcode = SUB;
    @(posedge clock); #1;
    start = 1'b0; busValid = 1'b1; busIn = 8'h11;
    @(posedge clock); #1;
    busIn = 8'h22;
    @(posedge clock); #1;
    busValid = 1'b0;
    @(posedge clock); #1;
    check("pre_rst_wb_enable", busOutEnable, 1);
    #3;
    resetN = 1'b0;
    #1;
    check("rst_wb_enable_drop", busOutEnable, 0);
    check("rst_wb_state", {busy, done, busOut, aluOperandA}, 18'h0);
    @(posedge clock); #1;
    check("rst_wb_no_done", done, 0);
    resetN = 1'b1;
    last = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    run_illegal(3'b000, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    run_op(ADD, 8'hFF, 8'h01, 0, 0, 0, 1'b0, mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

    repeat (2) @(posedge clock);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
